// File: rtl/seg7_monitor_if.sv
// Bundle of the four segment buses, the error-clear strobe and the decoded
// results exchanged between a display driver model and the segment monitor.
interface seg7_monitor_if;
  logic [0:7] seg1;
  logic [0:7] seg2;
  logic [0:7] seg3;
  logic [0:7] seg4;
  logic       clr;
  logic [3:0] bcd1;
  logic [3:0] bcd2;
  logic [3:0] bcd3;
  logic [3:0] bcd4;
  logic       valid;
  logic       upd;
  logic       step_ok;
  logic       pat_err;
  logic       range_err;

  modport master (
    output seg1, seg2, seg3, seg4, clr,
    input  bcd1, bcd2, bcd3, bcd4, valid, upd, step_ok, pat_err, range_err
  );

  modport slave (
    input  seg1, seg2, seg3, seg4, clr,
    output bcd1, bcd2, bcd3, bcd4, valid, upd, step_ok, pat_err, range_err
  );
endinterface

// File: rtl/seg7_monitor.sv
// Observes four active-low seven-segment buses, debounces and decodes them to
// BCD, and checks the recovered MM:SS value for legality and 1 s stepping.
module seg7_monitor #(
  parameter int STABLE_CYCLES = 4
) (
  input logic          CLOCK_50,
  input logic          rst,
  seg7_monitor_if.slave mon
);
  localparam logic [15:0] STABLE = 16'(STABLE_CYCLES);

  logic [0:7]  seg_in [4];
  logic [15:0] cur;
  logic [3:0]  acc_all;
  logic [3:0]  leg_all;
  logic [3:0]  pat_hit;
  logic [3:0]  range_hit;
  logic        valid;
  logic [15:0] snap_reg;
  logic        snap_v_reg;
  logic        upd_reg;
  logic        step_ok_reg;
  logic        pat_err_reg;
  logic        range_err_reg;

  // Returns {legal, digit}; dp is already forced to 1 by the caller.
  function automatic logic [4:0] decode(input logic [0:7] p);
    logic [4:0] r;
    r = 5'b0_0000;
    case (p)
      8'b00000011: r = 5'b1_0000;
      8'b10011111: r = 5'b1_0001;
      8'b00100101: r = 5'b1_0010;
      8'b00001101: r = 5'b1_0011;
      8'b10011001: r = 5'b1_0100;
      8'b01001001: r = 5'b1_0101;
      8'b01000001: r = 5'b1_0110;
      8'b00011011: r = 5'b1_0111;
      8'b00000001: r = 5'b1_1000;
      8'b00001001: r = 5'b1_1001;
      default:     r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // BCD MM:SS plus one second, wrapping 59:59 to 00:00.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd5) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (v[11:8] != 4'd9) begin
          r[11:8] = v[11:8] + 4'd1;
        end else begin
          r[11:8] = 4'd0;
          r[15:12] = (v[15:12] != 4'd5) ? v[15:12] + 4'd1 : 4'd0;
        end
      end
    end
    return r;
  endfunction

  assign seg_in[0] = mon.seg1;
  assign seg_in[1] = mon.seg2;
  assign seg_in[2] = mon.seg3;
  assign seg_in[3] = mon.seg4;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      localparam bit IS_TENS = (gi % 2) == 1;
      logic [0:7]  sample;
      logic [0:7]  last_reg;
      logic [15:0] cnt_reg;
      logic        acc_reg;
      logic        leg_reg;
      logic [3:0]  bcd_reg;
      logic [4:0]  dec;
      logic        accept;

      assign sample = {seg_in[gi][0:6], 1'b1};
      assign dec    = decode(sample);
      // Acceptance happens exactly once per stable run: the edge where cnt
      // would reach the threshold.
      assign accept = (sample == last_reg) && (cnt_reg == STABLE - 16'd1);

      always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
          last_reg <= 8'hFF;
          cnt_reg  <= 16'd0;
          acc_reg  <= 1'b0;
          leg_reg  <= 1'b0;
          bcd_reg  <= 4'd0;
        end else if (sample != last_reg) begin
          last_reg <= sample;
          cnt_reg  <= 16'd1;
          acc_reg  <= 1'b0;
          leg_reg  <= 1'b0;
        end else if (cnt_reg < STABLE) begin
          cnt_reg <= cnt_reg + 16'd1;
          if (accept) begin
            acc_reg <= 1'b1;
            leg_reg <= dec[4];
            if (dec[4]) begin
              bcd_reg <= dec[3:0];
            end
          end
        end
      end

      assign cur[gi*4 +: 4] = bcd_reg;
      assign acc_all[gi]    = acc_reg;
      assign leg_all[gi]    = leg_reg;
      assign pat_hit[gi]    = accept && !dec[4];
      assign range_hit[gi]  = IS_TENS && accept && dec[4] && (dec[3:0] > 4'd5);
    end
  endgenerate

  assign valid = (&acc_all) && (&leg_all);

  // Snapshot survives valid dropping, so a glitch that settles back to the
  // same value produces no update.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      snap_reg      <= 16'd0;
      snap_v_reg    <= 1'b0;
      upd_reg       <= 1'b0;
      step_ok_reg   <= 1'b0;
      pat_err_reg   <= 1'b0;
      range_err_reg <= 1'b0;
    end else begin
      upd_reg     <= 1'b0;
      step_ok_reg <= 1'b0;
      if (valid && ((cur != snap_reg) || !snap_v_reg)) begin
        snap_reg    <= cur;
        snap_v_reg  <= 1'b1;
        upd_reg     <= 1'b1;
        step_ok_reg <= snap_v_reg && (cur == bcd_inc(snap_reg));
      end
      if (pat_hit != 4'd0) begin
        pat_err_reg <= 1'b1;
      end else if (mon.clr) begin
        pat_err_reg <= 1'b0;
      end
      if (range_hit != 4'd0) begin
        range_err_reg <= 1'b1;
      end else if (mon.clr) begin
        range_err_reg <= 1'b0;
      end
    end
  end

  assign mon.bcd1      = cur[3:0];
  assign mon.bcd2      = cur[7:4];
  assign mon.bcd3      = cur[11:8];
  assign mon.bcd4      = cur[15:12];
  assign mon.valid     = valid;
  assign mon.upd       = upd_reg;
  assign mon.step_ok   = step_ok_reg;
  assign mon.pat_err   = pat_err_reg;
  assign mon.range_err = range_err_reg;
endmodule

// File: tb/tb_seg7_monitor.sv
// Scoreboard bench for seg7_monitor: stimulus pushes expected updates derived
// from a seconds-count model, a monitor pops them whenever upd fires.
module tb_seg7_monitor;
  logic CLOCK_50 = 1'b0;
  logic rst;
  seg7_monitor_if mon ();

  seg7_monitor #(.STABLE_CYCLES(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .mon      (mon)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [15:0] v;
    logic        step;
  } exp_t;

  exp_t        exp_q [$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] msnap = 16'd0;
  bit          msnap_v = 1'b0;
  logic [0:7]  seg_tab [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic int to_sec(input logic [15:0] v);
    return int'(v[15:12]) * 600 + int'(v[11:8]) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] from_sec(input int s);
    int m;
    int ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] cur_val();
    return {mon.bcd4, mon.bcd3, mon.bcd2, mon.bcd1};
  endfunction

  task automatic drive_segs(input logic [15:0] v);
    mon.seg1 = seg_tab[v[3:0]];
    mon.seg2 = seg_tab[v[7:4]];
    mon.seg3 = seg_tab[v[11:8]];
    mon.seg4 = seg_tab[v[15:12]];
  endtask

  // A settled value produces an update only if it differs from the last one seen.
  task automatic model_val(input logic [15:0] v);
    exp_t e;
    if (!msnap_v || v != msnap) begin
      e.v    = v;
      e.step = msnap_v && (to_sec(v) == (to_sec(msnap) + 1) % 3600);
      exp_q.push_back(e);
    end
    msnap   = v;
    msnap_v = 1'b1;
  endtask

  task automatic apply(input logic [15:0] v, input int hold);
    drive_segs(v);
    model_val(v);
    repeat (hold) @(negedge CLOCK_50);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports an update.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLOCK_50);
      if (!rst) begin
        if (mon.upd) begin
          $display("upd value=%h step_ok=%b", cur_val(), mon.step_ok);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_upd: got value %h, required no update", cur_val());
          end else begin
            e = exp_q.pop_front();
            check("upd_value", 32'(cur_val()), 32'(e.v));
            check("step_ok", 32'(mon.step_ok), 32'(e.step));
          end
        end else begin
          check("step_ok_idle", 32'(mon.step_ok), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [15:0] v;
    int          r;
    seg_tab[0] = 8'b00000011;
    seg_tab[1] = 8'b10011111;
    seg_tab[2] = 8'b00100101;
    seg_tab[3] = 8'b00001101;
    seg_tab[4] = 8'b10011001;
    seg_tab[5] = 8'b01001001;
    seg_tab[6] = 8'b01000001;
    seg_tab[7] = 8'b00011011;
    seg_tab[8] = 8'b00000001;
    seg_tab[9] = 8'b00001001;

    rst = 1'b1;
    mon.clr  = 1'b0;
    mon.seg1 = 8'hFF;
    mon.seg2 = 8'hFF;
    mon.seg3 = 8'hFF;
    mon.seg4 = 8'hFF;
    repeat (2) @(negedge CLOCK_50);
    check("reset_valid", 32'(mon.valid), 32'd0);
    check("reset_upd", 32'(mon.upd), 32'd0);
    check("reset_step_ok", 32'(mon.step_ok), 32'd0);
    check("reset_pat_err", 32'(mon.pat_err), 32'd0);
    check("reset_range_err", 32'(mon.range_err), 32'd0);
    check("reset_bcd", 32'(cur_val()), 32'd0);

    // First acceptance: valid after exactly four edges.
    rst = 1'b0;
    drive_segs(16'h1234);
    model_val(16'h1234);
    repeat (3) begin
      @(negedge CLOCK_50);
      check("latency_valid_low", 32'(mon.valid), 32'd0);
    end
    @(negedge CLOCK_50);
    check("latency_valid_high", 32'(mon.valid), 32'd1);
    check("latency_bcd", 32'(cur_val()), 32'h1234);
    repeat (4) @(negedge CLOCK_50);

    apply(16'h1235, 8);
    apply(16'h1237, 8);
    apply(16'h5959, 8);
    apply(16'h0000, 8);
    apply(16'h0959, 8);
    apply(16'h1000, 8);

    v = 16'h1000;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 3);
      if (r <= 1) begin
        v = from_sec((to_sec(v) + 1) % 3600);
      end else if (r == 2) begin
        v = from_sec($urandom_range(0, 3599));
      end
      apply(v, $urandom_range(6, 10));
    end

    // One-cycle glitch on seconds-ones: valid drops for four cycles, no update.
    apply(16'h1234, 8);
    mon.seg1 = 8'hFF;
    @(negedge CLOCK_50);
    check("glitch_valid_low", 32'(mon.valid), 32'd0);
    mon.seg1 = seg_tab[4];
    repeat (3) begin
      @(negedge CLOCK_50);
      check("glitch_valid_low", 32'(mon.valid), 32'd0);
    end
    @(negedge CLOCK_50);
    check("glitch_valid_back", 32'(mon.valid), 32'd1);
    check("glitch_pat_err", 32'(mon.pat_err), 32'd0);
    repeat (3) @(negedge CLOCK_50);

    // Blank bus accepted as an illegal pattern, then cleared.
    mon.seg2 = 8'hFF;
    repeat (3) @(negedge CLOCK_50);
    check("blank_pat_err_early", 32'(mon.pat_err), 32'd0);
    @(negedge CLOCK_50);
    check("blank_pat_err", 32'(mon.pat_err), 32'd1);
    check("blank_valid", 32'(mon.valid), 32'd0);
    mon.clr = 1'b1;
    @(negedge CLOCK_50);
    mon.clr = 1'b0;
    check("clr_pat_err", 32'(mon.pat_err), 32'd0);
    @(negedge CLOCK_50);
    check("clr_pat_err_stays", 32'(mon.pat_err), 32'd0);

    // Seconds-tens of 6 decodes legally but is out of range.
    drive_segs(16'h1264);
    model_val(16'h1264);
    repeat (4) @(negedge CLOCK_50);
    check("range_err", 32'(mon.range_err), 32'd1);
    check("range_valid", 32'(mon.valid), 32'd1);
    check("range_pat_err", 32'(mon.pat_err), 32'd0);
    repeat (4) @(negedge CLOCK_50);

    // Reset in the middle of acceptance clears everything at once.
    drive_segs(16'h0506);
    repeat (2) @(negedge CLOCK_50);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(mon.valid), 32'd0);
    check("midrst_bcd", 32'(cur_val()), 32'd0);
    check("midrst_range_err", 32'(mon.range_err), 32'd0);
    check("midrst_upd", 32'(mon.upd), 32'd0);
    msnap_v = 1'b0;
    @(negedge CLOCK_50);
    rst = 1'b0;
    repeat (3) begin
      @(negedge CLOCK_50);
      check("postrst_valid_low", 32'(mon.valid), 32'd0);
    end
    @(negedge CLOCK_50);
    check("postrst_valid_high", 32'(mon.valid), 32'd1);
    check("postrst_bcd", 32'(cur_val()), 32'h0506);
    model_val(16'h0506);
    repeat (4) @(negedge CLOCK_50);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
